// File: rtl/sbox_ti_out_compress_if.sv
// Handshake and share bus between the GF(2^4) multiplier stage, the
// output compression stage and the state/MixColumns datapath.
interface sbox_ti_out_compress_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s0, in_s1, in_s2, in_s3;
    logic [3:0] in_s4, in_s5, in_s6, in_s7;
    logic [7:0] rnd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sh0;
    logic [7:0] out_sh1;

    modport master (
        output in_valid, in_s0, in_s1, in_s2, in_s3,
               in_s4, in_s5, in_s6, in_s7, rnd, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1
    );

    modport slave (
        input  in_valid, in_s0, in_s1, in_s2, in_s3,
               in_s4, in_s5, in_s6, in_s7, rnd, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1
    );
endinterface

// File: rtl/sbox_ti_out_compress.sv
// Masked S-box output stage: registers 8 nibble shares (glitch barrier),
// compresses to 2 byte shares, applies linear map + affine constant, remasks.
module sbox_ti_out_compress #(
    parameter logic [7:0] LIN_ROW0   = 8'h01,
    parameter logic [7:0] LIN_ROW1   = 8'h02,
    parameter logic [7:0] LIN_ROW2   = 8'h04,
    parameter logic [7:0] LIN_ROW3   = 8'h08,
    parameter logic [7:0] LIN_ROW4   = 8'h10,
    parameter logic [7:0] LIN_ROW5   = 8'h20,
    parameter logic [7:0] LIN_ROW6   = 8'h40,
    parameter logic [7:0] LIN_ROW7   = 8'h80,
    parameter logic [7:0] AFFINE_C   = 8'h63,
    parameter bit         REFRESH_EN = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     flush,
    sbox_ti_out_compress_if.slave   io
);

    localparam logic [7:0] ROWS [8] = '{LIN_ROW0, LIN_ROW1, LIN_ROW2, LIN_ROW3,
                                        LIN_ROW4, LIN_ROW5, LIN_ROW6, LIN_ROW7};

    function automatic logic [7:0] lin_map(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            y[i] = ^(ROWS[i] & x);
        end
        return y;
    endfunction

    logic       va_q, va_d;
    logic       vb_q, vb_d;
    logic [3:0] a_q [8];
    logic [3:0] a_d [8];
    logic [7:0] sh0_q, sh0_d;
    logic [7:0] sh1_q, sh1_d;

    logic       adv_a, adv_b, accept, load_b;
    logic [7:0] x0, x1, m;

    always_comb begin
        adv_b  = !vb_q | io.out_ready;
        adv_a  = !va_q | adv_b;
        // flush wins over accept and also blocks the B load so rnd is not consumed
        accept = io.in_valid & adv_a & !flush;
        load_b = adv_b & va_q & !flush;

        va_d = va_q;
        if (flush)      va_d = 1'b0;
        else if (adv_a) va_d = accept;

        vb_d = vb_q;
        if (flush)      vb_d = 1'b0;
        else if (adv_b) vb_d = va_q;

        a_d = a_q;
        if (accept) begin
            a_d = '{io.in_s0, io.in_s1, io.in_s2, io.in_s3,
                    io.in_s4, io.in_s5, io.in_s6, io.in_s7};
        end

        // Compression only ever sees registered shares
        x0 = {a_q[0] ^ a_q[1], a_q[4] ^ a_q[5]};
        x1 = {a_q[2] ^ a_q[3], a_q[6] ^ a_q[7]};
        m  = REFRESH_EN ? io.rnd : '0;

        sh0_d = sh0_q;
        sh1_d = sh1_q;
        if (load_b) begin
            sh0_d = lin_map(x0) ^ AFFINE_C ^ m;
            sh1_d = lin_map(x1) ^ m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
            a_q   <= '{default: '0};
            sh0_q <= '0;
            sh1_q <= '0;
        end else begin
            va_q  <= va_d;
            vb_q  <= vb_d;
            a_q   <= a_d;
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
        end
    end

    assign io.in_ready  = adv_a;
    assign io.out_valid = vb_q;
    assign io.out_sh0   = sh0_q;
    assign io.out_sh1   = sh1_q;

endmodule

// File: tb/tb_sbox_ti_out_compress.sv
// Directed bench for sbox_ti_out_compress: default, refresh-disabled and
// rotated-linear-map instances driven in lockstep.
module tb_sbox_ti_out_compress;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    always #5 clk = ~clk;

    sbox_ti_out_compress_if ifa ();
    sbox_ti_out_compress_if ifb ();
    sbox_ti_out_compress_if ifc ();

    assign ifb.in_valid = ifa.in_valid;  assign ifc.in_valid = ifa.in_valid;
    assign ifb.in_s0 = ifa.in_s0;        assign ifc.in_s0 = ifa.in_s0;
    assign ifb.in_s1 = ifa.in_s1;        assign ifc.in_s1 = ifa.in_s1;
    assign ifb.in_s2 = ifa.in_s2;        assign ifc.in_s2 = ifa.in_s2;
    assign ifb.in_s3 = ifa.in_s3;        assign ifc.in_s3 = ifa.in_s3;
    assign ifb.in_s4 = ifa.in_s4;        assign ifc.in_s4 = ifa.in_s4;
    assign ifb.in_s5 = ifa.in_s5;        assign ifc.in_s5 = ifa.in_s5;
    assign ifb.in_s6 = ifa.in_s6;        assign ifc.in_s6 = ifa.in_s6;
    assign ifb.in_s7 = ifa.in_s7;        assign ifc.in_s7 = ifa.in_s7;
    assign ifb.rnd = ifa.rnd;            assign ifc.rnd = ifa.rnd;
    assign ifb.out_ready = ifa.out_ready; assign ifc.out_ready = ifa.out_ready;

    sbox_ti_out_compress u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .io(ifa.slave)
    );

    sbox_ti_out_compress #(.REFRESH_EN(1'b0)) u_norf (
        .clk(clk), .rst_n(rst_n), .flush(flush), .io(ifb.slave)
    );

    // Output bit i = x[(i+1)%8], i.e. rotate right by one
    sbox_ti_out_compress #(
        .LIN_ROW0(8'h02), .LIN_ROW1(8'h04), .LIN_ROW2(8'h08), .LIN_ROW3(8'h10),
        .LIN_ROW4(8'h20), .LIN_ROW5(8'h40), .LIN_ROW6(8'h80), .LIN_ROW7(8'h01)
    ) u_rot (
        .clk(clk), .rst_n(rst_n), .flush(flush), .io(ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] s);
        ifa.in_valid = v;
        ifa.in_s0 = s[31:28]; ifa.in_s1 = s[27:24];
        ifa.in_s2 = s[23:20]; ifa.in_s3 = s[19:16];
        ifa.in_s4 = s[15:12]; ifa.in_s5 = s[11:8];
        ifa.in_s6 = s[7:4];   ifa.in_s7 = s[3:0];
    endtask

    function automatic logic [7:0] lmap(input logic [7:0] x, input bit rot);
        return rot ? {x[0], x[7:1]} : x;
    endfunction

    function automatic logic [7:0] exp0(input logic [31:0] s, input logic [7:0] r, input bit rot);
        logic [7:0] x;
        x = {s[31:28] ^ s[27:24], s[15:12] ^ s[11:8]};
        return lmap(x, rot) ^ 8'h63 ^ r;
    endfunction

    function automatic logic [7:0] exp1(input logic [31:0] s, input logic [7:0] r, input bit rot);
        logic [7:0] x;
        x = {s[23:20] ^ s[19:16], s[7:4] ^ s[3:0]};
        return lmap(x, rot) ^ r;
    endfunction

    task automatic chk_out(input string tag, input logic [31:0] s, input logic [7:0] r);
        chk({tag, "_valid"}, {7'd0, ifa.out_valid}, 8'd1);
        chk({tag, "_sh0"}, ifa.out_sh0, exp0(s, r, 1'b0));
        chk({tag, "_sh1"}, ifa.out_sh1, exp1(s, r, 1'b0));
        chk({tag, "_xor"}, ifa.out_sh0 ^ ifa.out_sh1, exp0(s, 8'h00, 1'b0) ^ exp1(s, 8'h00, 1'b0));
        chk({tag, "_rot_sh0"}, ifc.out_sh0, exp0(s, r, 1'b1));
        chk({tag, "_rot_sh1"}, ifc.out_sh1, exp1(s, r, 1'b1));
    endtask

    localparam logic [31:0] V1 = 32'h1248_0F55;
    localparam logic [31:0] V2 = 32'h3A5C_9E71;
    localparam logic [31:0] V3 = 32'hF0F0_1234;

    logic [31:0] vec [16];
    logic [7:0]  rn  [16];

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0); ifa.rnd = 8'h00; ifa.out_ready = 1'b1;
        #2;
        // Reset state
        chk("rst_out_valid", {7'd0, ifa.out_valid}, 8'd0);
        chk("rst_sh0", ifa.out_sh0, 8'h00);
        chk("rst_sh1", ifa.out_sh1, 8'h00);
        chk("rst_in_ready", {7'd0, ifa.in_ready}, 8'd1);
        @(negedge clk); rst_n = 1'b1;

        // Single transfer, rnd = 00
        @(negedge clk); drive(1'b1, V1); ifa.rnd = 8'h00;
        @(negedge clk); drive(1'b0, V1);
        chk("t1_lat1_valid", {7'd0, ifa.out_valid}, 8'd0);
        @(negedge clk);
        chk("t1_valid", {7'd0, ifa.out_valid}, 8'd1);
        chk("t1_sh0", ifa.out_sh0, 8'h5C);
        chk("t1_sh1", ifa.out_sh1, 8'hC0);
        chk("t1_xor", ifa.out_sh0 ^ ifa.out_sh1, 8'h9C);
        chk("t1_norf_sh0", ifb.out_sh0, 8'h5C);
        chk("t1_norf_sh1", ifb.out_sh1, 8'hC0);
        chk("t1_rot_sh0", ifc.out_sh0, 8'hFC);
        chk("t1_rot_sh1", ifc.out_sh1, 8'h60);
        @(negedge clk);
        chk("t1_drain", {7'd0, ifa.out_valid}, 8'd0);

        // Refresh with rnd = A5
        drive(1'b1, V1); ifa.rnd = 8'hA5;
        @(negedge clk); drive(1'b0, V1);
        @(negedge clk);
        chk("t2_sh0", ifa.out_sh0, 8'hF9);
        chk("t2_sh1", ifa.out_sh1, 8'h65);
        chk("t2_xor", ifa.out_sh0 ^ ifa.out_sh1, 8'h9C);
        chk("t2_norf_sh0", ifb.out_sh0, 8'h5C);
        chk("t2_norf_sh1", ifb.out_sh1, 8'hC0);
        chk("t2_rot_sh0", ifc.out_sh0, 8'h59);
        chk("t2_rot_sh1", ifc.out_sh1, 8'hC5);
        @(negedge clk);

        // Backpressure: three vectors with out_ready low
        ifa.out_ready = 1'b0; ifa.rnd = 8'h3C;
        drive(1'b1, V1); #1;
        chk("bp_rdy1", {7'd0, ifa.in_ready}, 8'd1);
        @(negedge clk); drive(1'b1, V2); #1;
        chk("bp_rdy2", {7'd0, ifa.in_ready}, 8'd1);
        @(negedge clk); drive(1'b1, V3); #1;
        chk("bp_full_rdy", {7'd0, ifa.in_ready}, 8'd0);
        ifa.rnd = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out("bp_hold", V1, 8'h3C);
            chk("bp_hold_rdy", {7'd0, ifa.in_ready}, 8'd0);
        end
        ifa.rnd = 8'h3C;
        ifa.out_ready = 1'b1; #1;
        chk("bp_release_rdy", {7'd0, ifa.in_ready}, 8'd1);
        chk_out("bp_v1", V1, 8'h3C);
        @(negedge clk); drive(1'b0, V3);
        chk_out("bp_v2", V2, 8'h3C);
        @(negedge clk);
        chk_out("bp_v3", V3, 8'h3C);
        @(negedge clk);
        chk("bp_drain", {7'd0, ifa.out_valid}, 8'd0);

        // Back-to-back full rate
        for (int i = 0; i < 16; i++) begin
            vec[i] = $urandom;
            rn[i]  = 8'($urandom_range(0, 255));
        end
        for (int n = 0; n < 18; n++) begin
            if (n >= 2) chk_out("rate", vec[n-2], rn[n-2]);
            if (n < 16) drive(1'b1, vec[n]);
            else        drive(1'b0, 32'h0);
            if (n >= 1 && n <= 16) ifa.rnd = rn[n-1];
            #1;
            if (n < 16) chk("rate_rdy", {7'd0, ifa.in_ready}, 8'd1);
            @(negedge clk);
        end
        chk("rate_drain", {7'd0, ifa.out_valid}, 8'd0);

        // Flush with both stages full and input offered
        ifa.out_ready = 1'b0; ifa.rnd = 8'h11;
        drive(1'b1, V2);
        @(negedge clk); drive(1'b1, V3);
        @(negedge clk);
        chk_out("fl_pre", V2, 8'h11);
        flush = 1'b1; drive(1'b1, V1);
        @(negedge clk);
        flush = 1'b0; drive(1'b0, V1); ifa.out_ready = 1'b1;
        chk("fl_valid", {7'd0, ifa.out_valid}, 8'd0);
        chk("fl_sh0_kept", ifa.out_sh0, exp0(V2, 8'h11, 1'b0));
        @(negedge clk);
        chk("fl_valid2", {7'd0, ifa.out_valid}, 8'd0);
        @(negedge clk);
        chk("fl_valid3", {7'd0, ifa.out_valid}, 8'd0);

        // Asynchronous reset mid-stream
        ifa.rnd = 8'h00;
        drive(1'b1, V2);
        @(negedge clk); drive(1'b1, V3);
        @(negedge clk);
        chk("ar_pre_valid", {7'd0, ifa.out_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {7'd0, ifa.out_valid}, 8'd0);
        chk("ar_sh0", ifa.out_sh0, 8'h00);
        chk("ar_sh1", ifa.out_sh1, 8'h00);
        drive(1'b0, V3);
        @(negedge clk); rst_n = 1'b1;
        drive(1'b1, V1);
        @(negedge clk); drive(1'b0, V1);
        chk("ar_lat1", {7'd0, ifa.out_valid}, 8'd0);
        @(negedge clk);
        chk("ar_lat2_valid", {7'd0, ifa.out_valid}, 8'd1);
        chk("ar_sh0_after", ifa.out_sh0, 8'h5C);
        chk("ar_sh1_after", ifa.out_sh1, 8'hC0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
